// File: rtl/scemi_pipe_pkg.sv
// Shared types and constants for the SCE-MI input-pipe packer.
package scemi_pipe_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int DEF_MSG_WIDTH = 128;
  localparam int DEF_WIDTH     = 32;
  localparam int LEN_W         = 8;
  localparam int CNT_W         = 32;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/scemi_pipe_stat_ctr.sv
// Free-running statistics counter with enable; wraps on overflow.
module scemi_pipe_stat_ctr
  import scemi_pipe_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // count up by one on each enabled cycle
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + W'(1);
  end

  // counter register, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/scemi_pipe_packer.sv
// Splits a wide message into WIDTH-bit beats, LSB chunk first, for an
// input-pipe proxy. Back-to-back messages reload on the last beat.
// Optional statistics counters: define SCEMI_PIPE_PACKER_STATS_EN.
//
// state   | meaning
// IDLE    | no message held, ready to accept
// SEND    | shifting beats out, beats_q beats remain
//
// beats_q is LEN_W bits wide; BEATS is expected to fit in it.
module scemi_pipe_packer
  import scemi_pipe_pkg::*;
#(
  parameter int MSG_WIDTH = DEF_MSG_WIDTH,
  parameter int WIDTH     = DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [MSG_WIDTH-1:0] MSG,
  input  logic [LEN_W-1:0]     MSG_LEN,
  input  logic                 MSG_EN,
  output logic                 MSG_RDY,
  output logic [WIDTH-1:0]     DATA,
  output logic                 DATA_EN,
  input  logic                 DATA_RDY,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     MSG_COUNT,
  output logic [CNT_W-1:0]     BEAT_COUNT
);

  localparam int               BEATS   = ceil_div(MSG_WIDTH, WIDTH);
  localparam int               SR_W    = BEATS * WIDTH;
  localparam logic [LEN_W-1:0] BEATS_L = LEN_W'(BEATS);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [SR_W-1:0]  shift_q, shift_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [LEN_W-1:0] eff_len;
  logic             fire, last_beat, msg_rdy, accept;

  assign fire      = (state_q == ST_SEND) && DATA_RDY;
  assign last_beat = fire && (beats_q == LEN_ONE);
  assign msg_rdy   = (state_q == ST_IDLE) || last_beat;
  assign accept    = MSG_EN && msg_rdy;

  // zero or oversize length means the full message
  always_comb begin
    eff_len = MSG_LEN;
    if ((MSG_LEN == '0) || (MSG_LEN > BEATS_L)) eff_len = BEATS_L;
  end

  // state, shift register and beat counter registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beats_q <= beats_d;
    end
  end

  // next state: stay in SEND across a reload on the last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (last_beat && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath: load zero-extended message on accept, shift on each beat
  always_comb begin
    shift_d = shift_q;
    beats_d = beats_q;
    if (accept) begin
      shift_d = SR_W'(MSG);
      beats_d = eff_len;
    end else if (fire) begin
      shift_d = shift_q >> WIDTH;
      beats_d = beats_q - LEN_ONE;
    end
  end

  // outputs decoded from current state and downstream ready
  always_comb begin
    BUSY    = (state_q == ST_SEND);
    DATA_EN = fire;
    MSG_RDY = msg_rdy;
  end

  assign DATA = shift_q[WIDTH-1:0];

`ifdef SCEMI_PIPE_PACKER_STATS_EN
  scemi_pipe_stat_ctr #(.W(CNT_W)) u_msg_ctr (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (last_beat),
    .cnt  (MSG_COUNT)
  );

  scemi_pipe_stat_ctr #(.W(CNT_W)) u_beat_ctr (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (fire),
    .cnt  (BEAT_COUNT)
  );
`else
  assign MSG_COUNT  = '0;
  assign BEAT_COUNT = '0;
`endif

endmodule

// File: tb/tb_scemi_pipe_packer.sv
// Bench for scemi_pipe_packer: directed scenarios plus randomized traffic
// compared against a beat-queue reference model.
module tb_scemi_pipe_packer;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [127:0] MSG = '0;
  logic [7:0]   MSG_LEN = '0;
  logic         MSG_EN = 1'b0;
  logic         MSG_RDY;
  logic [31:0]  DATA;
  logic         DATA_EN;
  logic         DATA_RDY = 1'b1;
  logic         BUSY;
  logic [31:0]  MSG_COUNT, BEAT_COUNT;

  logic [39:0]  m40_msg = '0;
  logic [7:0]   m40_len = '0;
  logic         m40_en = 1'b0;
  logic         m40_rdy_o;
  logic [31:0]  m40_data;
  logic         m40_data_en;
  logic         m40_data_rdy = 1'b1;
  logic         m40_busy;
  logic [31:0]  m40_mcnt, m40_bcnt;

  scemi_pipe_packer dut (
    .CLK(CLK), .RST_N(RST_N), .MSG(MSG), .MSG_LEN(MSG_LEN), .MSG_EN(MSG_EN),
    .MSG_RDY(MSG_RDY), .DATA(DATA), .DATA_EN(DATA_EN), .DATA_RDY(DATA_RDY),
    .BUSY(BUSY), .MSG_COUNT(MSG_COUNT), .BEAT_COUNT(BEAT_COUNT)
  );

  scemi_pipe_packer #(.MSG_WIDTH(40), .WIDTH(32)) dut40 (
    .CLK(CLK), .RST_N(RST_N), .MSG(m40_msg), .MSG_LEN(m40_len), .MSG_EN(m40_en),
    .MSG_RDY(m40_rdy_o), .DATA(m40_data), .DATA_EN(m40_data_en),
    .DATA_RDY(m40_data_rdy), .BUSY(m40_busy), .MSG_COUNT(m40_mcnt),
    .BEAT_COUNT(m40_bcnt)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // reference model: beats still owed to the wire, plus message/beat tallies
  logic [31:0] exp_q[$];
  logic [31:0] mdl_msgs  = '0;
  logic [31:0] mdl_beats = '0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef SCEMI_PIPE_PACKER_STATS_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; MSG_EN = 1'b0; DATA_RDY = 1'b1; m40_en = 1'b0; m40_data_rdy = 1'b1;
    @(posedge CLK);
    exp_q.delete();
    mdl_msgs  = '0;
    mdl_beats = '0;
    #1;
    check_val("rst_data_en", 128'(DATA_EN), 128'(1'b0));
    check_val("rst_busy",    128'(BUSY),    128'(1'b0));
    check_val("rst_data",    128'(DATA),    128'(32'h0));
    check_val("rst_msg_cnt", 128'(MSG_COUNT),  128'(32'h0));
    check_val("rst_beat_cnt",128'(BEAT_COUNT), 128'(32'h0));
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // one clock: drive, check against model, then advance model at the edge
  task automatic step(input logic en, input logic [7:0] len, input logic [127:0] msg,
                      input logic rdy, output logic [31:0] o_data, output logic o_en,
                      output logic o_mrdy);
    logic e_busy, e_en, e_mrdy;
    int   n;
    @(negedge CLK);
    MSG_EN = en; MSG_LEN = len; MSG = msg; DATA_RDY = rdy;
    #1;
    e_busy = (exp_q.size() != 0);
    e_en   = e_busy && rdy;
    e_mrdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && rdy);
    check_val("busy",    128'(BUSY),    128'(e_busy));
    check_val("data_en", 128'(DATA_EN), 128'(e_en));
    check_val("msg_rdy", 128'(MSG_RDY), 128'(e_mrdy));
    if (e_busy) check_val("data", 128'(DATA), 128'(exp_q[0]));
    check_val("msg_count",  128'(MSG_COUNT),  128'(stat_exp(mdl_msgs)));
    check_val("beat_count", 128'(BEAT_COUNT), 128'(stat_exp(mdl_beats)));
    o_data = DATA; o_en = DATA_EN; o_mrdy = MSG_RDY;
    @(posedge CLK);
    if (e_en) begin
      void'(exp_q.pop_front());
      mdl_beats++;
      if (exp_q.size() == 0) mdl_msgs++;
    end
    if (en && e_mrdy) begin
      n = ((len == 0) || (len > 8'd4)) ? 4 : int'(len);
      for (int i = 0; i < n; i++) exp_q.push_back(msg[32*i +: 32]);
    end
  endtask

  localparam logic [127:0] M1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] M2 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

  initial begin
    logic [31:0] d;
    logic        e, r;
    logic [31:0] beats32 [4];
    beats32[0] = 32'h1111_1111; beats32[1] = 32'h2222_2222;
    beats32[2] = 32'h3333_3333; beats32[3] = 32'h4444_4444;

    // full-length message, downstream always ready
    do_reset();
    step(1'b1, 8'd0, M1, 1'b1, d, e, r);
    check_val("b1_accept_rdy", 128'(r), 128'(1'b1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'd0, '0, 1'b1, d, e, r);
      check_val($sformatf("b1_data%0d", i), 128'(d), 128'(beats32[i]));
      check_val($sformatf("b1_en%0d", i),   128'(e), 128'(1'b1));
    end
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    check_val("b1_idle_en", 128'(e), 128'(1'b0));
    check_val("b1_msg_cnt",  128'(MSG_COUNT),  128'(stat_exp(32'd1)));
    check_val("b1_beat_cnt", 128'(BEAT_COUNT), 128'(stat_exp(32'd4)));

    // stall on beats 2-3
    do_reset();
    step(1'b1, 8'd0, M1, 1'b1, d, e, r);
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    check_val("st_d0", 128'(d), 128'(32'h1111_1111));
    step(1'b0, 8'd0, '0, 1'b0, d, e, r);
    check_val("st_hold1", 128'(d), 128'(32'h2222_2222));
    check_val("st_hold1_en", 128'(e), 128'(1'b0));
    step(1'b0, 8'd0, '0, 1'b0, d, e, r);
    check_val("st_hold2", 128'(d), 128'(32'h2222_2222));
    check_val("st_hold2_en", 128'(e), 128'(1'b0));
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 8'd0, '0, 1'b1, d, e, r);
      check_val($sformatf("st_d%0d", i), 128'(d), 128'(beats32[i]));
      check_val($sformatf("st_en%0d", i), 128'(e), 128'(1'b1));
    end
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    check_val("st_beat_cnt", 128'(BEAT_COUNT), 128'(stat_exp(32'd4)));

    // back-to-back two-beat messages
    do_reset();
    step(1'b1, 8'd2, M1, 1'b1, d, e, r);
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    check_val("bb_d0", 128'(d), 128'(32'h1111_1111));
    check_val("bb_rdy0", 128'(r), 128'(1'b0));
    step(1'b1, 8'd2, M2, 1'b1, d, e, r);
    check_val("bb_d1", 128'(d), 128'(32'h2222_2222));
    check_val("bb_rdy_last", 128'(r), 128'(1'b1));
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    check_val("bb_d2", 128'(d), 128'(32'h5555_5555));
    check_val("bb_en2", 128'(e), 128'(1'b1));
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    check_val("bb_d3", 128'(d), 128'(32'h6666_6666));
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    check_val("bb_idle", 128'(e), 128'(1'b0));
    check_val("bb_msg_cnt", 128'(MSG_COUNT), 128'(stat_exp(32'd2)));

    // reset in the middle of a message
    do_reset();
    step(1'b1, 8'd0, M1, 1'b1, d, e, r);
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    step(1'b0, 8'd0, '0, 1'b1, d, e, r);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'd0, '0, 1'b1, d, e, r);
      check_val($sformatf("mr_no_beat%0d", i), 128'(e), 128'(1'b0));
    end

    // 40-bit message over 32-bit beats: padded last chunk
    do_reset();
    @(negedge CLK);
    m40_msg = 40'hAB_1234_5678; m40_len = 8'd0; m40_en = 1'b1; m40_data_rdy = 1'b1;
    #1 check_val("w40_rdy", 128'(m40_rdy_o), 128'(1'b1));
    @(negedge CLK);
    m40_en = 1'b0;
    #1;
    check_val("w40_d0", 128'(m40_data), 128'(32'h1234_5678));
    check_val("w40_en0", 128'(m40_data_en), 128'(1'b1));
    @(negedge CLK);
    #1;
    check_val("w40_d1", 128'(m40_data), 128'(32'h0000_00AB));
    check_val("w40_en1", 128'(m40_data_en), 128'(1'b1));
    @(negedge CLK);
    #1;
    check_val("w40_done", 128'(m40_busy), 128'(1'b0));

    // randomized traffic with occasional resets
    do_reset();
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)),
                {$urandom, $urandom, $urandom, $urandom},
                ($urandom_range(0, 3) != 0), d, e, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
